// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the data memory responder: MMIO word offsets inside
// the 8-word I/O window and the bit positions inside TIMER_CTRL.
package data_memory_responder_pkg;

  typedef enum logic [2:0] {
    MMIO_GPIO_OUT    = 3'd0,
    MMIO_GPIO_IN     = 3'd1,
    MMIO_TIMER_COUNT = 3'd2,
    MMIO_TIMER_CMP   = 3'd3,
    MMIO_TIMER_CTRL  = 3'd4,
    MMIO_CYCLE       = 3'd5,
    MMIO_RSVD6       = 3'd6,
    MMIO_RSVD7       = 3'd7
  } mmio_off_e;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_AUTOCLEAR = 1;
  localparam int CTRL_PENDING   = 2;

endpackage

// File: rtl/data_memory_responder_mmio_timer.sv
// Compare timer: COUNT, CMP and CTRL registers with match and W1C handling.
// Ports:
//   clock, reset          - sole clock, synchronous active-high reset
//   wr_count/cmp/ctrl     - per-register write strobes from the address decode
//   wdata                 - CPU write data
//   count, cmp, ctrl      - register values for the read mux
//   irq                   - TIMER_CTRL.pending
module mmio_timer
  import data_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_count,
  input  logic                  wr_cmp,
  input  logic                  wr_ctrl,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0] cmp,
  output logic [DATA_WIDTH-1:0] ctrl,
  output logic                  irq
);

  logic enable;
  logic autoclear;
  logic pending;
  logic match;

  // Match always looks at the pre-edge count, even when the CPU is
  // overwriting COUNT in the same cycle.
  assign match = enable && (count == cmp);

  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      cmp       <= '1;
      enable    <= 1'b0;
      autoclear <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= wdata;
      end else if (enable) begin
        count <= (match && autoclear) ? '0 : count + DATA_WIDTH'(1);
      end

      if (wr_cmp) begin
        cmp <= wdata;
      end

      if (wr_ctrl) begin
        enable    <= wdata[CTRL_ENABLE];
        autoclear <= wdata[CTRL_AUTOCLEAR];
      end

      // A new match beats a simultaneous write-1-to-clear.
      if (match) begin
        pending <= 1'b1;
      end else if (wr_ctrl && wdata[CTRL_PENDING]) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    ctrl                 = '0;
    ctrl[CTRL_ENABLE]    = enable;
    ctrl[CTRL_AUTOCLEAR] = autoclear;
    ctrl[CTRL_PENDING]   = pending;
  end

  assign irq = pending;

endmodule

// File: rtl/data_memory_responder.sv
// Responder on the CPU data memory port: word-addressed RAM plus an 8-word
// MMIO window (GPIO, compare timer, cycle counter) at the top of the space.
// Ports:
//   clock, reset   - sole clock, synchronous active-high reset
//   mem_addr       - word address from CPU
//   mem_wenable    - write strobe, one word per cycle
//   mem_wvalue     - write data
//   mem_rvalue     - combinational read data for mem_addr
//   gpio_in        - asynchronous input pins (synchronized internally)
//   gpio_out       - GPIO output register
//   timer_irq      - timer pending flag
//   bus_error      - sticky flag, set by any access outside RAM and MMIO
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 16,
  parameter int          RAM_DEPTH  = 256,
  parameter int unsigned MMIO_BASE  = (2 ** ADDR_WIDTH) - 8,
  parameter int          GPIO_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_wenable,
  input  logic [DATA_WIDTH-1:0] mem_wvalue,
  output logic [DATA_WIDTH-1:0] mem_rvalue,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq,
  output logic                  bus_error
);

  localparam int                  RAM_AW      = $clog2(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RAM_LIMIT = ADDR_WIDTH'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MMIO_LO   = ADDR_WIDTH'(MMIO_BASE);

  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];

  logic                  is_ram;
  logic                  is_mmio;
  mmio_off_e             off;
  logic                  wr_mmio;
  logic [GPIO_WIDTH-1:0] gpio_sync1;
  logic [GPIO_WIDTH-1:0] gpio_sync2;
  logic [DATA_WIDTH-1:0] cycle;
  logic [DATA_WIDTH-1:0] t_count;
  logic [DATA_WIDTH-1:0] t_cmp;
  logic [DATA_WIDTH-1:0] t_ctrl;

  assign is_ram  = (mem_addr < RAM_LIMIT);
  assign is_mmio = (mem_addr >= MMIO_LO);

  // The window is 8 words and never crosses the top of the address space,
  // so the low three bits of the difference are the whole offset.
  assign off     = mmio_off_e'(mem_addr[2:0] - MMIO_LO[2:0]);
  assign wr_mmio = mem_wenable && is_mmio && !reset;

  always_ff @(posedge clock) begin
    if (mem_wenable && is_ram && !reset) begin
      ram[mem_addr[RAM_AW-1:0]] <= mem_wvalue;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
      cycle      <= '0;
      bus_error  <= 1'b0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
      cycle      <= cycle + DATA_WIDTH'(1);
      if (wr_mmio && off == MMIO_GPIO_OUT) begin
        gpio_out <= mem_wvalue[GPIO_WIDTH-1:0];
      end
      if (!is_ram && !is_mmio) begin
        bus_error <= 1'b1;
      end
    end
  end

  mmio_timer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .wr_count (wr_mmio && off == MMIO_TIMER_COUNT),
    .wr_cmp   (wr_mmio && off == MMIO_TIMER_CMP),
    .wr_ctrl  (wr_mmio && off == MMIO_TIMER_CTRL),
    .wdata    (mem_wvalue),
    .count    (t_count),
    .cmp      (t_cmp),
    .ctrl     (t_ctrl),
    .irq      (timer_irq)
  );

  always_comb begin
    mem_rvalue = '0;
    if (is_ram) begin
      mem_rvalue = ram[mem_addr[RAM_AW-1:0]];
    end else if (is_mmio) begin
      case (off)
        MMIO_GPIO_OUT:    mem_rvalue[GPIO_WIDTH-1:0] = gpio_out;
        MMIO_GPIO_IN:     mem_rvalue[GPIO_WIDTH-1:0] = gpio_sync2;
        MMIO_TIMER_COUNT: mem_rvalue = t_count;
        MMIO_TIMER_CMP:   mem_rvalue = t_cmp;
        MMIO_TIMER_CTRL:  mem_rvalue = t_ctrl;
        MMIO_CYCLE:       mem_rvalue = cycle;
        default:          mem_rvalue = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  logic        clock;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_wenable;
  logic [15:0] mem_wvalue;
  logic [15:0] mem_rvalue;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic        bus_error;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] A_GOUT  = 16'hFFF8;
  localparam logic [15:0] A_GIN   = 16'hFFF9;
  localparam logic [15:0] A_COUNT = 16'hFFFA;
  localparam logic [15:0] A_CMP   = 16'hFFFB;
  localparam logic [15:0] A_CTRL  = 16'hFFFC;
  localparam logic [15:0] A_CYCLE = 16'hFFFD;

  data_memory_responder dut (
    .clock       (clock),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_wenable (mem_wenable),
    .mem_wvalue  (mem_wvalue),
    .mem_rvalue  (mem_rvalue),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .timer_irq   (timer_irq),
    .bus_error   (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp_r;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] a, input logic w, input logic [15:0] d,
                     input logic c, input logic [15:0] er, input logic ei);
    vec_t v;
    v.addr = a; v.we = w; v.wdata = d; v.chk = c; v.exp_r = er; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Drive a cycle's inputs and move to the sampling point (falling edge).
  task automatic apply(input logic [15:0] a, input logic w, input logic [15:0] d);
    mem_addr    = a;
    mem_wenable = w;
    mem_wvalue  = d;
    @(negedge clock);
  endtask

  task automatic finish_cycle();
    @(posedge clock);
    #1;
    mem_wenable = 1'b0;
    mem_addr    = 16'h0000;
  endtask

  initial begin
    reset = 1'b1; mem_addr = 0; mem_wenable = 0; mem_wvalue = 0; gpio_in = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_irq", 32'(timer_irq), 32'h0);
    chk("rst_bus_error", 32'(bus_error), 32'h0);

    // addr, we, wdata, check rvalue, expected rvalue (pre-edge), expected irq
    add(A_CMP,   0, 16'h0,    1, 16'hFFFF, 0);
    add(A_COUNT, 0, 16'h0,    1, 16'h0000, 0);
    add(A_CTRL,  0, 16'h0,    1, 16'h0000, 0);
    add(16'd6,   1, 16'hBEEF, 0, 16'h0000, 0);
    add(16'd5,   1, 16'h1234, 0, 16'h0000, 0);
    add(16'd5,   0, 16'h0,    1, 16'h1234, 0);
    add(16'd6,   0, 16'h0,    1, 16'hBEEF, 0);
    add(A_CMP,   1, 16'h0003, 1, 16'hFFFF, 0);
    add(A_CMP,   0, 16'h0,    1, 16'h0003, 0);
    add(A_CTRL,  1, 16'h0003, 1, 16'h0000, 0);
    add(A_COUNT, 0, 16'h0,    1, 16'h0000, 0);
    add(A_COUNT, 0, 16'h0,    1, 16'h0001, 0);
    add(A_COUNT, 0, 16'h0,    1, 16'h0002, 0);
    add(A_COUNT, 0, 16'h0,    1, 16'h0003, 0);
    add(A_COUNT, 0, 16'h0,    1, 16'h0000, 1);
    add(A_CTRL,  0, 16'h0,    1, 16'h0007, 1);
    add(A_CTRL,  1, 16'h0004, 1, 16'h0007, 1);
    add(A_CTRL,  0, 16'h0,    1, 16'h0000, 0);
    add(A_COUNT, 0, 16'h0,    1, 16'h0003, 0);
    add(A_CTRL,  1, 16'h0001, 1, 16'h0000, 0);
    add(A_COUNT, 1, 16'h0040, 1, 16'h0003, 0);
    add(A_COUNT, 0, 16'h0,    1, 16'h0040, 1);
    add(A_COUNT, 0, 16'h0,    1, 16'h0041, 1);
    add(A_CTRL,  1, 16'h0004, 1, 16'h0005, 1);
    add(A_CTRL,  0, 16'h0,    1, 16'h0000, 0);
    add(A_CMP,   1, 16'h0010, 1, 16'h0003, 0);
    add(A_COUNT, 1, 16'h000E, 1, 16'h0043, 0);
    add(A_CTRL,  1, 16'h0001, 1, 16'h0000, 0);
    add(A_COUNT, 0, 16'h0,    1, 16'h000E, 0);
    add(A_COUNT, 0, 16'h0,    1, 16'h000F, 0);
    add(A_CTRL,  1, 16'h0005, 1, 16'h0001, 0);
    add(A_CTRL,  0, 16'h0,    1, 16'h0005, 1);
    add(A_COUNT, 0, 16'h0,    1, 16'h0012, 1);
    add(A_CTRL,  1, 16'h0004, 1, 16'h0005, 1);
    add(A_CTRL,  0, 16'h0,    1, 16'h0000, 0);
    add(16'hFFFE, 0, 16'h0,   1, 16'h0000, 0);
    add(16'hFFFF, 1, 16'h1234, 1, 16'h0000, 0);
    add(16'hFFFF, 0, 16'h0,   1, 16'h0000, 0);
    add(A_GIN,   0, 16'h0,    1, 16'h0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].addr, vecs[i].we, vecs[i].wdata);
      if (vecs[i].chk) chk($sformatf("vec%0d_rvalue", i), 32'(mem_rvalue), 32'(vecs[i].exp_r));
      chk($sformatf("vec%0d_irq", i), 32'(timer_irq), 32'(vecs[i].exp_irq));
      finish_cycle();
    end
    chk("reserved_no_bus_error", 32'(bus_error), 32'h0);

    // GPIO output register
    apply(A_GOUT, 1, 16'h003C);
    chk("gout_pre_write", 32'(mem_rvalue), 32'h0);
    finish_cycle();
    chk("gpio_out_pin", 32'(gpio_out), 32'h3C);
    apply(A_GOUT, 0, 16'h0);
    chk("gout_readback", 32'(mem_rvalue), 32'h3C);
    finish_cycle();

    // One-cycle gpio_in pulse shows up exactly two edges later
    gpio_in = 8'hA5;
    apply(A_GIN, 0, 16'h0);
    chk("gin_edge0", 32'(mem_rvalue), 32'h0);
    finish_cycle();
    gpio_in = 8'h00;
    apply(A_GIN, 0, 16'h0);
    chk("gin_edge1", 32'(mem_rvalue), 32'h0);
    finish_cycle();
    apply(A_GIN, 0, 16'h0);
    chk("gin_edge2", 32'(mem_rvalue), 32'hA5);
    finish_cycle();
    apply(A_GIN, 0, 16'h0);
    chk("gin_edge3", 32'(mem_rvalue), 32'h0);
    finish_cycle();

    // Unmapped access and sticky bus_error
    apply(16'h0100, 0, 16'h0);
    chk("unmapped_read", 32'(mem_rvalue), 32'h0);
    chk("bus_error_before", 32'(bus_error), 32'h0);
    finish_cycle();
    chk("bus_error_set", 32'(bus_error), 32'h1);
    apply(16'd5, 0, 16'h0);
    chk("ram5_after_err", 32'(mem_rvalue), 32'h1234);
    finish_cycle();
    chk("bus_error_sticky", 32'(bus_error), 32'h1);
    apply(16'h0200, 1, 16'hDEAD);
    finish_cycle();
    apply(16'h0200, 0, 16'h0);
    chk("unmapped_write_dropped", 32'(mem_rvalue), 32'h0);
    finish_cycle();

    // Reset discards concurrent writes
    apply(16'd0, 1, 16'h1111);
    finish_cycle();
    reset = 1'b1;
    apply(A_GOUT, 1, 16'h0077);
    finish_cycle();
    apply(16'd0, 1, 16'h2222);
    chk("ram0_read_in_reset", 32'(mem_rvalue), 32'h1111);
    finish_cycle();
    reset = 1'b0;
    chk("post_rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("post_rst_bus_error", 32'(bus_error), 32'h0);
    chk("post_rst_irq", 32'(timer_irq), 32'h0);
    apply(A_CYCLE, 0, 16'h0);
    chk("cycle_first", 32'(mem_rvalue), 32'h0);
    finish_cycle();
    apply(A_CYCLE, 0, 16'h0);
    chk("cycle_second", 32'(mem_rvalue), 32'h1);
    finish_cycle();
    apply(16'd0, 0, 16'h0);
    chk("ram0_kept", 32'(mem_rvalue), 32'h1111);
    finish_cycle();
    apply(A_CMP, 0, 16'h0);
    chk("post_rst_cmp", 32'(mem_rvalue), 32'hFFFF);
    finish_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
